// File: rtl/mem_pkg.sv
// Shared memory-access definitions: size codes, store-buffer entry type,
// access length decode and the load sign/zero-extension helper.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  // Entries hold addresses zero-padded to this width so one entry type serves
  // every ADDR_W up to 16; the padding also gives range maths headroom.
  localparam int SB_AW = 16;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [31:0]      data;
    logic [1:0]       size;
  } sb_entry_t;

  // Bytes touched by an access; the reserved code 11 is treated as a word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      MEM_BYTE: size_to_len = 3'd1;
      MEM_HALF: size_to_len = 3'd2;
      default:  size_to_len = 3'd4;
    endcase
  endfunction

  // Extend the low byte/half of an LSB-aligned value to 32 bits.
  function automatic logic [31:0] ld_extend(input logic [31:0] data,
                                            input logic [1:0]  size,
                                            input logic        sign);
    case (size)
      MEM_BYTE: ld_extend = {{24{sign & data[7]}}, data[7:0]};
      MEM_HALF: ld_extend = {{16{sign & data[15]}}, data[15:0]};
      default:  ld_extend = data;
    endcase
  endfunction

endpackage

// File: rtl/sb_overlap.sv
// Per-entry comparator: does a load's byte range intersect this store entry,
// and (with STORE_BUF_FWD_EN) is it an exact addr/size match.
module sb_overlap
  import mem_pkg::*;
#(
  parameter int AW = SB_AW
) (
  input  logic          valid,
  input  logic [AW-1:0] e_addr,
  input  logic [1:0]    e_size,
  input  logic [AW-1:0] l_addr,
  input  logic [1:0]    l_size,
  output logic          hit
`ifdef STORE_BUF_FWD_EN
  ,
  output logic          exact
`endif
);

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] e_lo, e_hi, l_lo, l_hi;

  // Inclusive byte ranges, one bit wider than the address so the top never wraps.
  always_comb begin
    e_lo = {1'b0, e_addr};
    l_lo = {1'b0, l_addr};
    e_hi = e_lo + (AW+1)'(size_to_len(e_size)) - ONE;
    l_hi = l_lo + (AW+1)'(size_to_len(l_size)) - ONE;
    hit  = valid && (l_lo <= e_hi) && (e_lo <= l_hi);
  end

`ifdef STORE_BUF_FWD_EN
  // Exact match means the entry supplies every byte the load wants.
  assign exact = hit && (e_addr == l_addr) && (e_size == l_size);
`endif

endmodule

// File: rtl/store_buffer.sv
// Store buffer in front of data_memory: FIFO of committed stores drained one
// per cycle, loads take the port unless they overlap a pending store.
// Optional macro STORE_BUF_FWD_EN: forward exact-match youngest store to load.
//
// Handshake: a store transfers on a rising edge where st_valid && st_ready;
// st_ready depends only on the registered count. A load is serviced in any
// cycle where ld_valid && !ld_stall; while stalled the requester holds it.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_sign,
  output logic              ld_stall,
  output logic [31:0]       ld_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic              mem_sign,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);

  sb_entry_t        fifo [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;
  logic             full, push, drain;
  logic [DEPTH-1:0] ent_valid, hit;
  logic             any_hit;
  sb_entry_t        head_e;
  logic [SB_AW-1:0] ld_addr_x;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign st_ready  = !full;
  assign push      = st_valid && !full;
  assign head_e    = fifo[head];
  assign ld_addr_x = SB_AW'(ld_addr);
  assign any_hit   = |hit;

`ifdef STORE_BUF_FWD_EN
  logic [DEPTH-1:0] exact;
  logic             yng_exact;
  logic [31:0]      yng_data;
`endif

  // One comparator per slot; a slot is live if its age from head is < count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] age;
    assign age          = PW'(i) - head;
    assign ent_valid[i] = ({1'b0, age} < count);
    sb_overlap #(.AW(SB_AW)) u_ovl (
      .valid  (ent_valid[i]),
      .e_addr (fifo[i].addr),
      .e_size (fifo[i].size),
      .l_addr (ld_addr_x),
      .l_size (ld_size),
      .hit    (hit[i])
`ifdef STORE_BUF_FWD_EN
      ,
      .exact  (exact[i])
`endif
    );
  end

`ifdef STORE_BUF_FWD_EN
  // Walk oldest to youngest so the last overlapping slot seen wins.
  always_comb begin
    yng_exact = 1'b0;
    yng_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (hit[head + PW'(k)]) begin
        yng_exact = exact[head + PW'(k)];
        yng_data  = fifo[head + PW'(k)].data;
      end
    end
  end
`endif

  // Port arbitration: full drains first, then a clean load, then drains.
  always_comb begin
    drain     = 1'b0;
    ld_stall  = 1'b0;
    ld_data   = '0;
    mem_we    = 1'b0;
    mem_addr  = head_e.addr[ADDR_W-1:0];
    mem_size  = head_e.size;
    mem_sign  = 1'b0;
    mem_wdata = '0;
    if (full) begin
      drain    = 1'b1;
      ld_stall = ld_valid;
    end else if (ld_valid && !any_hit) begin
      mem_addr = ld_addr;
      mem_size = ld_size;
      mem_sign = ld_sign;
      ld_data  = mem_rdata;
    end else if (ld_valid) begin
      drain = 1'b1;
`ifdef STORE_BUF_FWD_EN
      if (yng_exact) ld_data = ld_extend(yng_data, ld_size, ld_sign);
      else           ld_stall = 1'b1;
`else
      ld_stall = 1'b1;
`endif
    end else if (!empty) begin
      drain = 1'b1;
    end
    if (drain) begin
      mem_we    = 1'b1;
      mem_wdata = head_e.data;
    end
  end

  // FIFO storage and pointers; reset discards everything pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[tail] <= '{addr: SB_AW'(st_addr), data: st_data, size: st_size};
        tail       <= tail + 1'b1;
      end
      if (drain) head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer with a byte-array data_memory model
// and a queue-based reference of pending stores.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int MSIZE  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              st_valid, st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic              ld_valid, ld_stall, ld_sign;
  logic [ADDR_W-1:0] ld_addr;
  logic [1:0]        ld_size;
  logic [31:0]       ld_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_size;
  logic              mem_sign, mem_we, empty;
  logic [31:0]       mem_wdata, mem_rdata, rd_raw;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [1:0]        size;
  } st_t;

  st_t        pend_q[$];
  logic [7:0] env_mem [MSIZE];
  logic [7:0] ref_mem [MSIZE];
  logic       mem_ready = 1'b0;
  int         checks = 0;
  int         failures = 0;
  logic       obs_stall, obs_st_ready;
  logic [31:0] obs_ld_data;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_size(st_size),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_sign(ld_sign), .ld_stall(ld_stall), .ld_data(ld_data),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_sign(mem_sign),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .empty(empty)
  );

  function automatic int tlen(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] t_ext(input logic [31:0] raw, input logic [1:0] s, input logic sg);
    if (s == 2'd0) return sg ? 32'($signed(raw[7:0])) : {24'd0, raw[7:0]};
    if (s == 2'd1) return sg ? 32'($signed(raw[15:0])) : {16'd0, raw[15:0]};
    return raw;
  endfunction

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 113 + 7) & 255);
  endfunction

  // data_memory stand-in: combinational read, byte writes on the clock edge.
  always_comb begin
    rd_raw = {env_mem[mem_addr + 10'd3], env_mem[mem_addr + 10'd2],
              env_mem[mem_addr + 10'd1], env_mem[mem_addr]};
    mem_rdata = t_ext(rd_raw, mem_size, mem_sign);
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < MSIZE; a++) env_mem[a] <= pat(a);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      for (int b = 0; b < tlen(mem_size); b++)
        env_mem[mem_addr + ADDR_W'(b)] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a, input logic [1:0] s, input logic sg);
    logic [31:0] raw;
    for (int b = 0; b < 4; b++) raw[8*b +: 8] = ref_mem[a + ADDR_W'(b)];
    return t_ext(raw, s, sg);
  endfunction

  function automatic bit ranges_meet(input int a0, input int l0, input int a1, input int l1);
    return (a0 <= a1 + l1 - 1) && (a1 <= a0 + l0 - 1);
  endfunction

  task automatic idle_inputs();
    st_valid = 0; st_addr = '0; st_data = '0; st_size = '0;
    ld_valid = 0; ld_addr = '0; ld_size = '0; ld_sign = 0;
  endtask

  // One clock: check outputs mid-cycle against the reference, then advance it.
  task automatic cycle();
    int   n;
    bit   full, ovl, fwd, e_stall, e_drain, e_push;
    st_t  yng, hd;
    logic [31:0] e_ld;
    @(negedge clk);
    n = pend_q.size();
    full = (n == DEPTH);
    ovl = 0; fwd = 0;
    for (int i = 0; i < n; i++)
      if (ranges_meet(int'(pend_q[i].addr), tlen(pend_q[i].size), int'(ld_addr), tlen(ld_size))) begin
        ovl = 1; yng = pend_q[i];
      end
`ifdef STORE_BUF_FWD_EN
    fwd = ovl && (yng.addr == ld_addr) && (yng.size == ld_size);
`endif
    e_stall = ld_valid && (full || (ovl && !fwd));
    e_drain = (n > 0) && (full || (ld_valid && ovl) || !ld_valid);
    e_push  = st_valid && !full;
    check("st_ready", st_ready, !full);
    check("empty", empty, n == 0);
    check("ld_stall", ld_stall, e_stall);
    check("mem_we", mem_we, e_drain);
    if (e_drain) begin
      hd = pend_q[0];
      check("drain_addr", mem_addr, hd.addr);
      check("drain_data", mem_wdata, hd.data);
      check("drain_size", mem_size, hd.size);
      check("drain_sign", mem_sign, 0);
    end
    if (ld_valid && !e_stall) begin
      e_ld = fwd ? t_ext(yng.data, ld_size, ld_sign) : ref_read(ld_addr, ld_size, ld_sign);
      check("ld_data", ld_data, e_ld);
      if (!fwd) check("ld_port_addr", mem_addr, ld_addr);
    end
    obs_stall = ld_stall; obs_ld_data = ld_data; obs_st_ready = st_ready;
    @(posedge clk);
    if (e_drain) begin
      hd = pend_q.pop_front();
      for (int b = 0; b < tlen(hd.size); b++) ref_mem[hd.addr + ADDR_W'(b)] = hd.data[8*b +: 8];
    end
    if (e_push) pend_q.push_back('{addr: st_addr, data: st_data, size: st_size});
    #1;
  endtask

  task automatic put_store(input int a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1; st_addr = ADDR_W'(a); st_data = d; st_size = s;
  endtask

  task automatic put_load(input int a, input logic [1:0] s, input logic sg);
    ld_valid = 1; ld_addr = ADDR_W'(a); ld_size = s; ld_sign = sg;
  endtask

  // Hold the current load until serviced; returns stall cycles seen.
  task automatic hold_load(output int stalls);
    stalls = 0;
    for (int k = 0; k < 4 * DEPTH; k++) begin
      cycle();
      if (!obs_stall) break;
      stalls++;
    end
  endtask

  initial begin
    int  stalls, diff;
    bit  saw_full;
    for (int a = 0; a < MSIZE; a++) ref_mem[a] = pat(a);
    idle_inputs();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_st_ready", st_ready, 1);
    check("rst_mem_we", mem_we, 0);
    check("rst_ld_stall", ld_stall, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_size", mem_size, 0);
    check("rst_mem_sign", mem_sign, 0);
    check("rst_ld_data", ld_data, 0);
    reset_n = 1;
    cycle();

    // Store then drain, then read back through memory.
    put_store(16'h010, 32'hDEADBEEF, 2'b10); cycle();
    idle_inputs(); cycle();
    cycle();
    put_load(16'h010, 2'b10, 0); cycle();
    check("t1_ld_word", obs_ld_data, 32'hDEADBEEF);
    idle_inputs();

    // Fill past DEPTH while a non-overlapping load is held.
    saw_full = 0;
    put_load(16'h200, 2'b10, 0);
    for (int k = 0; k <= DEPTH; k++) begin
      put_store(16'h100 + 4 * k, $urandom, 2'b10);
      for (int w = 0; w < 8; w++) begin
        cycle();
        if (!obs_st_ready) saw_full = 1;
        if (obs_st_ready) break;
      end
    end
    st_valid = 0;
    check("t2_saw_full", saw_full, 1);
    idle_inputs();
    repeat (DEPTH + 1) cycle();

    // Partial overlap: byte store under a half load stalls until drained.
    put_store(16'h021, 32'h00000080, 2'b00); cycle();
    st_valid = 0;
    put_load(16'h020, 2'b01, 1);
    hold_load(stalls);
    check("t3_stalled", stalls > 0, 1);
    check("t3_bound", stalls <= DEPTH, 1);
    check("t3_ld_hi", {8'd0, obs_ld_data[31:8]}, 32'h00FFFF80);
    idle_inputs(); cycle();

    // Exact match: forwarded with the macro, stalled without.
    put_store(16'h030, 32'h00008001, 2'b01); cycle();
    st_valid = 0;
    put_load(16'h030, 2'b01, 1); cycle();
`ifdef STORE_BUF_FWD_EN
    check("t4_fwd_stall", obs_stall, 0);
    check("t4_fwd_data", obs_ld_data, 32'hFFFF8001);
`else
    check("t4_nofwd_stall", obs_stall, 1);
    hold_load(stalls);
    check("t4_ld_data", obs_ld_data, 32'hFFFF8001);
`endif
    idle_inputs(); repeat (2) cycle();

    // Misaligned word store covering the byte load address.
    put_store(16'h03E, 32'hA1B2C3D4, 2'b10); cycle();
    st_valid = 0;
    put_load(16'h041, 2'b00, 0); cycle();
    check("t5_stall", obs_stall, 1);
    hold_load(stalls);
    check("t5_ld_data", obs_ld_data, 32'h000000A1);
    idle_inputs(); cycle();

    // Reset with two stores pending: nothing may reach memory.
    put_load(16'h280, 2'b10, 0);
    put_store(16'h240, 32'h11111111, 2'b10); cycle();
    put_store(16'h244, 32'h22222222, 2'b10); cycle();
    st_valid = 0;
    cycle();
    #2 reset_n = 0; ld_valid = 0;
    #1;
    check("t6_empty", empty, 1);
    check("t6_mem_we", mem_we, 0);
    @(posedge clk); #1;
    check("t6_mem_we_hold", mem_we, 0);
    pend_q.delete();
    reset_n = 1;
    idle_inputs(); cycle();

    // Random traffic in a small window to provoke overlaps.
    for (int c = 0; c < 1500; c++) begin
      if (!st_valid || obs_st_ready) begin
        if ($urandom_range(0, 2) == 0)
          put_store(16'h300 + $urandom_range(0, 15), $urandom, 2'($urandom_range(0, 3)));
        else
          st_valid = 0;
      end
      if (!ld_valid || !obs_stall) begin
        if ($urandom_range(0, 1) == 0)
          put_load(16'h300 + $urandom_range(0, 15), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        else
          ld_valid = 0;
      end
      cycle();
    end
    idle_inputs();
    for (int k = 0; k < 2 * DEPTH + 4; k++) begin
      cycle();
      if (pend_q.size() == 0 && empty) break;
    end
    check("final_empty", empty, 1);

    diff = 0;
    for (int a = 0; a < MSIZE; a++) if (env_mem[a] !== ref_mem[a]) diff++;
    check("mem_image", diff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store buffer between the execute/memory pipeline stage and `data_memory`. Queues committed stores in a small FIFO and drains them into the single memory port one per cycle. Gives loads port priority and detects byte overlap between a load and pending stores, stalling or forwarding. Drives `data_memory`'s address/size/sign/write inputs directly and returns load data to the pipeline.

## Interface
- `DEPTH`, 4: store entries; power of two, 2..16.
- `ADDR_W`, 10: byte address width, matching `data_memory`.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `st_valid` in 1: store request.
- `st_ready` out 1: buffer can accept a store.
- `st_addr` in ADDR_W: store byte address.
- `st_data` in 32: store data, LSB-aligned.
- `st_size` in 2: 00 byte, 01 half, 10 word.
- `ld_valid` in 1: load request.
- `ld_addr` in ADDR_W: load byte address.
- `ld_size` in 2: load size, same encoding.
- `ld_sign` in 1: 1 signed, 0 unsigned.
- `ld_stall` out 1: load not serviced this cycle; hold request.
- `ld_data` out 32: extended load result, valid when `ld_valid && !ld_stall`.
- `mem_addr` out ADDR_W, `mem_size` out 2, `mem_sign` out 1, `mem_we` out 1, `mem_wdata` out 32: to `data_memory`.
- `mem_rdata` in 32: `data_memory` read data.
- `empty` out 1: no pending stores (fence/drain wait).

## Operation
- FIFO of {addr, data, size}; head/tail pointers log2(DEPTH) bits, count log2(DEPTH)+1 bits.
- Enqueue on edge with `st_valid && st_ready`; `st_ready = !full`. No enqueue-into-full even if draining that cycle.
- Byte range of an access: [addr, addr+len-1] computed in ADDR_W+1 bits; len 1/2/4; size 11 counts as len 4. No wrap at top of memory.
- Overlap: load range intersects any valid entry's range.
- Port arbitration per cycle, in order:
  1. full: drain head; `ld_stall = ld_valid`.
  2. `ld_valid`, no overlap: load owns port; `mem_we=0`, `mem_addr/size/sign` = load fields, `ld_data = mem_rdata`; no drain.
  3. `ld_valid`, overlap: `ld_stall=1`; drain head (forwarding: see Configuration).
  4. no load, not empty: drain head.
  5. idle: `mem_we=0`, `mem_addr`=head addr, `mem_size`=head size.
- Drain: `mem_we=1`, `mem_addr/size/wdata` = head, `mem_sign=0`; head pops on that edge.
- Simultaneous enqueue and drain: count unchanged.
- Stores are written to memory in program order, never merged.

## Timing
- Reset values: count 0, pointers 0, `empty=1`, `st_ready=1`, `mem_we=0`, `ld_stall=0`, `mem_addr=0`, `mem_wdata=0`, `mem_size=0`, `mem_sign=0`, `ld_data=0`.
- Reset mid-operation discards all pending stores.
- A store enqueued at edge N is visible to the overlap check from cycle N+1. Its earliest memory write is edge N+1.
- Loads are combinational: `ld_data` is valid in the same cycle as `ld_valid` when not stalled.
- An overlapping load stalls at most until the overlapping entries drain, i.e. at most DEPTH cycles.
- `empty`, `st_ready`: decoded from registered count only.

## Configuration
- `STORE_BUF_FWD_EN` defined: if the youngest overlapping entry has the same addr and size as the load, set `ld_stall=0`. `ld_data` is that entry's data, byte/half sign- or zero-extended per `ld_sign`. The port drains the head in the same cycle. Any other overlap stalls.
- Undefined: any overlap stalls.

## Structure
- Package `mem_pkg`:
  - size constants `MEM_BYTE`/`MEM_HALF`/`MEM_WORD`;
  - `sb_entry_t` typedef;
  - `size_to_len` function;
  - shared load-extension function.
- Sub-module `sb_overlap`: one per entry; range-intersect and exact-match compare, combinational.

## Test plan
- Reset, store word 0xDEADBEEF @0x010, idle → `mem_we=1` next cycle, `mem_addr=0x010`, `empty=1` after; load word @0x010 returns 0xDEADBEEF.
- DEPTH+1 back-to-back stores with `ld_valid` held on a non-overlapping address → `st_ready=0` when full; drain wins; load stalls that cycle only.
- Store byte 0x80 @0x021, then load half signed @0x020 next cycle → `ld_stall=1` until drained, then 0xFFFF80xx per memory contents.
- With `STORE_BUF_FWD_EN`: store half 0x8001 @0x030, load half signed @0x030 → no stall, `ld_data=0xFFFF8001`. Without the macro → stall.
- Misaligned store word @0x03E with load byte @0x041 → overlap detected, stall.
- Two stores pending, `reset_n` low mid-cycle → `empty=1`, `mem_we=0` immediately; no writes reach memory.
